// File: rtl/sar_pkg.sv
// Shared types and default sizing for the successive-approximation searcher.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_e;

  localparam int SAR_WIDTH = 8;
  localparam int SAR_CNT_W = 4;

endpackage : sar_pkg

// File: rtl/sar_search.sv
// Binary-searches a target held on the comparator's b input, one bit per clock.
// Optional build macro SAR_SEARCH_PROTOCOL_CHECK_EN adds a sticky err output for non-one-hot flags.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  parameter int CNT_W = SAR_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] steps
`ifdef SAR_SEARCH_PROTOCOL_CHECK_EN
  ,
  output logic             err
`endif
);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] steps_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] trial;
  logic             takeBit;
  logic             lastBit;
  logic             flagsBad;

  assign trial   = acc_q | ({{(WIDTH-1){1'b0}}, 1'b1} << k_q);
  assign lastBit = (k_q == '0);
  // A clear gt means the target is at or above the trial; no flag at all counts as lt.
  assign takeBit = !gt && (lt || !eq);
  assign acc_d   = takeBit ? trial : acc_q;

`ifdef SAR_SEARCH_PROTOCOL_CHECK_EN
  assign flagsBad = ({1'b0, gt} + {1'b0, eq} + {1'b0, lt}) != 2'd1;
`else
  assign flagsBad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEARCH;
      SEARCH: begin
        if (flagsBad)          state_d = IDLE;
        else if (eq || lastBit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    guess = '0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        guess = trial;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      k_q      <= CNT_W'(WIDTH - 1);
      steps_q  <= '0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        acc_q   <= '0;
        k_q     <= CNT_W'(WIDTH - 1);
        steps_q <= '0;
      end else if (state_q == SEARCH) begin
        steps_q <= steps_q + 1'b1;
        if (!flagsBad) begin
          if (eq) begin
            result_q <= trial;
          end else begin
            acc_q <= acc_d;
            if (lastBit) result_q <= acc_d;
            else         k_q      <= k_q - 1'b1;
          end
        end
      end
    end
  end

`ifdef SAR_SEARCH_PROTOCOL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            err_q <= 1'b0;
    else if (state_q == SEARCH && flagsBad) err_q <= 1'b1;
  end

  assign err = err_q;
`endif

  assign result = result_q;
  assign steps  = steps_q;

endmodule : sar_search
